// File: rtl/sd_pkg.sv
// Shared definitions for the SD card command path: command index constants,
// the dummy/idle bus byte, R1 bit positions and the command engine state type.
package sd_pkg;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD24  = 6'd24;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD58  = 6'd58;

    localparam logic [7:0] DUMMY_BYTE = 8'hFF;

    localparam int R1_IDLE        = 0;
    localparam int R1_ILLEGAL_CMD = 2;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SEND,
        POLL,
        EXT,
        FIN,
        POST
    } sd_state_e;

endpackage

// File: rtl/sd_crc7.sv
// CRC7 (x^7 + x^3 + 1, init 0) over a 40-bit block, MSB first.
// Purely combinational so it can be shared with the data-path block.
//   data : 40-bit message (command byte + 32-bit argument)
//   crc  : 7-bit remainder
module sd_crc7 (
    input  logic [39:0] data,
    output logic [6:0]  crc
);

    logic [6:0] rem;
    logic       fb;

    always_comb begin
        rem = 7'd0;
        fb  = 1'b0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ rem[6];
            rem = {rem[5:0], 1'b0};
            if (fb) begin
                rem = rem ^ 7'h09;
            end
        end
        crc = rem;
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD command engine: frames one command (index, argument, CRC7), drives it
// byte by byte into the SPI master, polls for R1, optionally collects the
// 4-byte R3/R7 payload and sequences chip select including the trailing
// dummy byte.
//   cmd_*   : command request handshake and attributes (captured on accept)
//   cs_release : release a held chip select from IDLE
//   rsp_*   : completion pulse plus R1 / extended payload / timeout flag
//   spi_*   : one-byte-at-a-time interface to the SPI master, chip select
//
// state | meaning
// IDLE  | waiting for a command or a cs_release; CS may be held low
// PRE   | sending PRE_DUMMY 0xFF bytes with CS low
// SEND  | sending the 6 frame bytes
// POLL  | sending 0xFF until an R1 (bit7 == 0) or RESP_TIMEOUT bytes
// EXT   | collecting the 4 R3/R7 payload bytes
// FIN   | decide: keep CS low and finish, or raise CS and go to POST
// POST  | one 0xFF with CS high, then back to IDLE
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int RESP_TIMEOUT = 8,
    parameter int PRE_DUMMY    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        cmd_resp_long,
    input  logic        cmd_hold_cs,
    input  logic        cs_release,
    output logic        rsp_valid,
    output logic [7:0]  rsp_r1,
    output logic [31:0] rsp_ext,
    output logic        rsp_timeout,
    output logic        spi_req,
    output logic [7:0]  spi_tx,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx,
    output logic        spi_cs_n
);

    localparam logic [2:0] PRE_LOAD  = (PRE_DUMMY == 0) ? 3'd5 : 3'(PRE_DUMMY - 1);
    localparam logic [7:0] POLL_LOAD = 8'(RESP_TIMEOUT - 1);

    sd_state_e   state, state_nxt;
    logic        outstanding;
    logic [47:0] frame;
    logic [2:0]  byte_left;
    logic [7:0]  poll_left;
    logic        long_r, hold_r, releasing;
    logic [7:0]  r1_r;
    logic [31:0] ext_r;
    logic        to_r, rsp_valid_r, cs_n_r;
    logic [6:0]  crc_in;
    logic        issue;
    logic [7:0]  tx_byte;
    logic        byte_done, release_go, accept;

    sd_crc7 u_crc7 (
        .data ({2'b01, cmd_index, cmd_arg}),
        .crc  (crc_in)
    );

    // spi_done only counts when a byte is actually in flight.
    assign byte_done  = spi_done && outstanding;
    assign release_go = (state == IDLE) && cs_release && !cs_n_r;
    assign accept     = (state == IDLE) && cmd_valid && !release_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        tx_byte   = DUMMY_BYTE;
        case (state)
            IDLE: begin
                if (release_go) begin
                    state_nxt = POST;
                end else if (cmd_valid) begin
                    state_nxt = (PRE_DUMMY == 0) ? SEND : PRE;
                end
            end
            PRE: begin
                issue = 1'b1;
                if (byte_done && byte_left == 3'd0) state_nxt = SEND;
            end
            SEND: begin
                issue   = 1'b1;
                tx_byte = frame[47:40];
                if (byte_done && byte_left == 3'd0) state_nxt = POLL;
            end
            POLL: begin
                issue = 1'b1;
                if (byte_done) begin
                    if (!spi_rx[7]) begin
                        state_nxt = long_r ? EXT : FIN;
                    end else if (poll_left == 8'd0) begin
                        state_nxt = FIN;
                    end
                end
            end
            EXT: begin
                issue = 1'b1;
                if (byte_done && byte_left == 3'd0) state_nxt = FIN;
            end
            FIN: begin
                state_nxt = (hold_r && !to_r) ? IDLE : POST;
            end
            POST: begin
                issue = 1'b1;
                if (byte_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new byte may start only when nothing is in flight and the master is
    // not completing one this very cycle.
    assign spi_req   = issue && !outstanding && !spi_done;
    assign spi_tx    = tx_byte;
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 1'b0;
            frame       <= '0;
            byte_left   <= 3'd0;
            poll_left   <= 8'd0;
            long_r      <= 1'b0;
            hold_r      <= 1'b0;
            releasing   <= 1'b0;
            r1_r        <= 8'hFF;
            ext_r       <= '0;
            to_r        <= 1'b0;
            rsp_valid_r <= 1'b0;
            cs_n_r      <= 1'b1;
        end else begin
            rsp_valid_r <= 1'b0;
            if (byte_done) begin
                outstanding <= 1'b0;
            end else if (spi_req) begin
                outstanding <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (release_go) begin
                        cs_n_r    <= 1'b1;
                        releasing <= 1'b1;
                    end else if (accept) begin
                        cs_n_r    <= 1'b0;
                        frame     <= {2'b01, cmd_index, cmd_arg, crc_in, 1'b1};
                        long_r    <= cmd_resp_long;
                        hold_r    <= cmd_hold_cs;
                        r1_r      <= 8'hFF;
                        ext_r     <= '0;
                        to_r      <= 1'b0;
                        byte_left <= PRE_LOAD;
                        releasing <= 1'b0;
                    end
                end
                PRE: begin
                    if (byte_done) begin
                        byte_left <= (byte_left == 3'd0) ? 3'd5 : byte_left - 3'd1;
                    end
                end
                SEND: begin
                    if (byte_done) begin
                        frame <= {frame[39:0], 8'h00};
                        if (byte_left == 3'd0) begin
                            poll_left <= POLL_LOAD;
                        end else begin
                            byte_left <= byte_left - 3'd1;
                        end
                    end
                end
                POLL: begin
                    if (byte_done) begin
                        if (!spi_rx[7]) begin
                            r1_r      <= spi_rx;
                            byte_left <= 3'd3;
                        end else if (poll_left == 8'd0) begin
                            to_r <= 1'b1;
                        end else begin
                            poll_left <= poll_left - 8'd1;
                        end
                    end
                end
                EXT: begin
                    if (byte_done) begin
                        ext_r <= {ext_r[23:0], spi_rx};
                        if (byte_left != 3'd0) byte_left <= byte_left - 3'd1;
                    end
                end
                FIN: begin
                    if (hold_r && !to_r) begin
                        rsp_valid_r <= 1'b1;
                    end else begin
                        cs_n_r <= 1'b1;
                    end
                end
                POST: begin
                    if (byte_done) begin
                        rsp_valid_r <= !releasing;
                        releasing   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_r;
    assign rsp_r1      = r1_r;
    assign rsp_ext     = ext_r;
    assign rsp_timeout = to_r;
    assign spi_cs_n    = cs_n_r;

endmodule
